// File: rtl/spu_pkg.sv
// Shared parameters and types for the SPU instruction line buffer fill path.
// Exports line/slot/beat geometry and the fill controller state encoding.
package spu_pkg;

    localparam int LS_LINE_W = 12;
    localparam int SLOTS     = 16;
    localparam int BEATS     = 4;
    localparam int QW_W      = 128;
    localparam int SLOT_W    = 4;
    localparam int TAG_W     = LS_LINE_W - SLOT_W;
    localparam int CNT_W     = 3;
    localparam int QADDR_W   = LS_LINE_W + 2;
    localparam int QIDX_W    = SLOT_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } fill_state_t;

endpackage

// File: rtl/ilb_tag_array.sv
// Tag/valid store for the direct-mapped instruction line buffer.
// Ports: clk/rst_ni, inv_all_i (clear all), clr_* (drop one slot),
// wr_* (mark slot valid with tag), lk_a/lk_b comb hit lookups.
module ilb_tag_array
    import spu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_ni,
    input  logic                 inv_all_i,
    input  logic                 clr_en_i,
    input  logic [SLOT_W-1:0]    clr_slot_i,
    input  logic                 wr_en_i,
    input  logic [SLOT_W-1:0]    wr_slot_i,
    input  logic [TAG_W-1:0]     wr_tag_i,
    input  logic [LS_LINE_W-1:0] lk_a_line_i,
    output logic                 lk_a_hit_o,
    input  logic [LS_LINE_W-1:0] lk_b_line_i,
    output logic                 lk_b_hit_o
);

    logic [SLOTS-1:0] valid_q;
    logic [SLOTS-1:0] valid_d;
    logic [TAG_W-1:0] tag_q [SLOTS];

    // Invalidate-all overrides any same-edge set, so an aborted
    // fill can never leave a line marked valid.
    always_comb begin
        valid_d = valid_q;
        if (clr_en_i) valid_d[clr_slot_i] = 1'b0;
        if (wr_en_i)  valid_d[wr_slot_i]  = 1'b1;
        if (inv_all_i) valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < SLOTS; i++) tag_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            if (wr_en_i) tag_q[wr_slot_i] <= wr_tag_i;
        end
    end

    assign lk_a_hit_o = valid_q[lk_a_line_i[SLOT_W-1:0]] &&
        (tag_q[lk_a_line_i[SLOT_W-1:0]] ==
         lk_a_line_i[LS_LINE_W-1:SLOT_W]);

    assign lk_b_hit_o = valid_q[lk_b_line_i[SLOT_W-1:0]] &&
        (tag_q[lk_b_line_i[SLOT_W-1:0]] ==
         lk_b_line_i[LS_LINE_W-1:SLOT_W]);

endmodule

// File: rtl/ins_line_fill.sv
// Instruction line buffer fill controller: hit lookup, LS line fetch.
// Ports: fill_* (fetch handshake), lookup_*, inv_all, ls_* (LS read), buf_wr_*.
module ins_line_fill
    import spu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fill_req,
    input  logic [LS_LINE_W-1:0] fill_line,
    output logic                 fill_accept,
    output logic                 fill_done,
    output logic                 busy,
    input  logic [LS_LINE_W-1:0] lookup_line,
    output logic                 lookup_hit,
    input  logic                 inv_all,
    output logic                 ls_rd_req,
    output logic [QADDR_W-1:0]   ls_rd_addr,
    input  logic                 ls_gnt,
    input  logic                 ls_rd_valid,
    input  logic [QW_W-1:0]      ls_rd_data,
    output logic                 buf_wr_en,
    output logic [QIDX_W-1:0]    buf_wr_qidx,
    output logic [QW_W-1:0]      buf_wr_data
);

    localparam logic [CNT_W-1:0] NBEAT = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BEATS - 1);

    fill_state_t            state_q, state_d;
    logic [LS_LINE_W-1:0]   line_q, line_d;
    logic [CNT_W-1:0]       req_q, req_d;
    logic [CNT_W-1:0]       rsp_q, rsp_d;
    logic                   done_q, done_d;
    logic                   fill_hit;
    logic                   clr_en;
    logic                   set_en;

    ilb_tag_array u_tags (
        .clk         (clk),
        .rst_ni      (reset),
        .inv_all_i   (inv_all),
        .clr_en_i    (clr_en),
        .clr_slot_i  (fill_line[SLOT_W-1:0]),
        .wr_en_i     (set_en),
        .wr_slot_i   (line_q[SLOT_W-1:0]),
        .wr_tag_i    (line_q[LS_LINE_W-1:SLOT_W]),
        .lk_a_line_i (lookup_line),
        .lk_a_hit_o  (lookup_hit),
        .lk_b_line_i (fill_line),
        .lk_b_hit_o  (fill_hit)
    );

    assign fill_accept = fill_req && (state_q == IDLE) && !inv_all;

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        req_d     = req_q;
        rsp_d     = rsp_q;
        done_d    = 1'b0;
        ls_rd_req = 1'b0;
        buf_wr_en = 1'b0;
        clr_en    = 1'b0;
        set_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fill_accept) begin
                    if (fill_hit) begin
                        done_d = 1'b1;
                    end else begin
                        clr_en  = 1'b1;
                        line_d  = fill_line;
                        req_d   = '0;
                        rsp_d   = '0;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                ls_rd_req = (req_q < NBEAT);
                if (ls_rd_req && ls_gnt) req_d = req_q + 1'b1;
                if (ls_rd_valid) begin
                    buf_wr_en = 1'b1;
                    rsp_d     = rsp_q + 1'b1;
                end
                if (ls_rd_valid && (rsp_q == LAST)) begin
                    // Final beat: commit unless an invalidate races it.
                    state_d = IDLE;
                    if (!inv_all) begin
                        set_en = 1'b1;
                        done_d = 1'b1;
                    end
                end else if (inv_all) begin
                    // Skip DRAIN when nothing is left in flight.
                    state_d = (req_d == rsp_d) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (ls_rd_valid) rsp_d = rsp_q + 1'b1;
                if (rsp_d == req_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            line_q  <= '0;
            req_q   <= '0;
            rsp_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            req_q   <= req_d;
            rsp_q   <= rsp_d;
            done_q  <= done_d;
        end
    end

    assign fill_done   = done_q;
    assign busy        = (state_q != IDLE);
    assign ls_rd_addr  = {line_q, req_q[1:0]};
    assign buf_wr_qidx = {line_q[SLOT_W-1:0], rsp_q[1:0]};
    assign buf_wr_data = ls_rd_data;

`ifndef SYNTHESIS
    a_no_stray_rsp: assert property (
        @(posedge clk) disable iff (!reset)
        ls_rd_valid |-> (state_q != IDLE && rsp_q < req_q)
    );
`endif

endmodule
